// File: rtl/system_top.sv
// system_top: multi-cycle MIPS-subset core sharing one synchronous word RAM
// with a host port (tbCTRL/REN/WEN/addr/store/load/halt).
// Optional switch/LED window enabled by defining SYSTEM_MMIO_EN.
module system_top #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] PC_RESET  = 32'h0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [17:0] SW,
    output logic [17:0] LEDR,
    input  logic        tbCTRL,
    input  logic        REN,
    input  logic        WEN,
    input  logic [31:0] addr,
    input  logic [31:0] store,
    output logic [31:0] load,
    output logic        halt
);
    localparam int AW = $clog2(RAM_WORDS);

`ifdef SYSTEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_ORI = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                           OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALTED} state_t;

    state_t      state, next_state;
    logic [31:0] pc, ir, rdata;
    logic [31:0] rf [32];
    logic [31:0] mem [0:RAM_WORDS-1];

    // During EXEC the instruction is still in the RAM read register; later
    // states use the copy latched at the end of EXEC.
    logic [31:0] cur_ir;
    assign cur_ir = (state == S_EXEC) ? rdata : ir;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext, zext, rs_val, rt_val, ea, pc4;
    logic signed [31:0] rs_s, rt_s;
    assign op     = cur_ir[31:26];
    assign rs     = cur_ir[25:21];
    assign rt     = cur_ir[20:16];
    assign rd     = cur_ir[15:11];
    assign shamt  = cur_ir[10:6];
    assign funct  = cur_ir[5:0];
    assign imm    = cur_ir[15:0];
    assign sext   = {{16{imm[15]}}, imm};
    assign zext   = {16'h0, imm};
    assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];
    assign rs_s   = rs_val;
    assign rt_s   = rt_val;
    assign ea     = rs_val + sext;
    assign pc4    = pc + 32'd4;

    // The I/O window decodes only the low 16 address bits, so $0-based
    // accesses with a sign-extended immediate such as 0xF004 reach it.
    logic led_hit, sw_hit;
    assign led_hit = MMIO_EN && (state == S_MEM) && (op == OP_SW) && (ea[15:2] == 14'h3C00);
    assign sw_hit  = MMIO_EN && (state == S_MEM) && (op == OP_LW) && (ea[15:2] == 14'h3C01);

    // ALU / branch decode for the EXEC cycle
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_val, pc_next;
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rd;
        wr_val  = 32'h0;
        pc_next = pc4;
        case (op)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    6'h21:   wr_val = rs_val + rt_val;
                    6'h23:   wr_val = rs_val - rt_val;
                    6'h24:   wr_val = rs_val & rt_val;
                    6'h25:   wr_val = rs_val | rt_val;
                    6'h2A:   wr_val = {31'h0, (rs_s < rt_s)};
                    6'h00:   wr_val = rt_val << shamt;
                    default: wr_en  = 1'b0;
                endcase
            end
            OP_ADDIU: begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_val + sext;      end
            OP_ORI:   begin wr_en = 1'b1; wr_idx = rt; wr_val = rs_val | zext;      end
            OP_LUI:   begin wr_en = 1'b1; wr_idx = rt; wr_val = {imm, 16'h0};       end
            OP_BEQ:   if (rs_val == rt_val) pc_next = pc4 + (sext << 2);
            OP_BNE:   if (rs_val != rt_val) pc_next = pc4 + (sext << 2);
            OP_J:     pc_next = {pc4[31:28], cur_ir[25:0], 2'b00};
            OP_HALT:  pc_next = pc;
            default:  ;
        endcase
    end

    // FSM state register; the core only advances while it owns the RAM
    always_ff @(posedge CLK) begin
        if (nRST)         state <= S_FETCH;
        else if (!tbCTRL) state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) next_state = S_MEM;
                else if (op == OP_HALT)         next_state = S_HALTED;
                else                            next_state = S_FETCH;
            end
            S_MEM:    next_state = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_HALTED;
        endcase
    end

    // FSM outputs: core-side RAM request
    logic        core_ren, core_wen;
    logic [31:0] core_addr, core_wdata;
    always_comb begin
        core_ren   = 1'b0;
        core_wen   = 1'b0;
        core_addr  = pc;
        core_wdata = rt_val;
        case (state)
            S_FETCH: core_ren = 1'b1;
            S_MEM: begin
                core_addr = ea;
                if (op == OP_SW) core_wen = !led_hit;
                else             core_ren = 1'b1;
            end
            default: ;
        endcase
    end

    // Core architectural state: PC, instruction latch, register file, halt
    always_ff @(posedge CLK) begin
        if (nRST) begin
            pc   <= PC_RESET;
            halt <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (!tbCTRL) begin
            case (state)
                S_EXEC: begin
                    ir <= rdata;
                    pc <= pc_next;
                    if (wr_en && wr_idx != 5'd0) rf[wr_idx] <= wr_val;
                    if (op == OP_HALT) halt <= 1'b1;
                end
                S_WB: if (rt != 5'd0) rf[rt] <= rdata;
                default: ;
            endcase
        end
    end

    // Single RAM port, owned by the host whenever tbCTRL is high
    logic [31:0]   ram_addr;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    assign ram_addr  = tbCTRL ? addr : core_addr;
    assign ram_idx   = ram_addr[AW+1:2];
    assign ram_we    = !nRST && (tbCTRL ? WEN : core_wen);
    assign ram_wdata = tbCTRL ? store : core_wdata;

    // RAM write (contents survive reset)
    always_ff @(posedge CLK) begin
        if (ram_we) mem[ram_idx] <= ram_wdata;
    end

    // Host read register; holds while the core owns the port
    always_ff @(posedge CLK) begin
        if (nRST)                load <= 32'h0;
        else if (tbCTRL && REN)  load <= mem[ram_idx];
    end

    // Core read register, also the path for the switch input window
    always_ff @(posedge CLK) begin
        if (!nRST && !tbCTRL && core_ren)
            rdata <= sw_hit ? {14'h0, SW} : mem[ram_idx];
    end

    // LED register, written only through the I/O window
    always_ff @(posedge CLK) begin
        if (nRST)                     LEDR <= 18'h0;
        else if (!tbCTRL && led_hit)  LEDR <= core_wdata[17:0];
    end

    logic unused_bits;
    assign unused_bits = ^{ram_addr[31:AW+2], ram_addr[1:0]};
endmodule

// File: tb/tb_system_top.sv
module tb_system_top;
    logic        CLK = 1'b0;
    logic        nRST, tbCTRL, REN, WEN;
    logic [17:0] SW, LEDR;
    logic [31:0] addr, store, load;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [$];
    logic [31:0] rd_val;
    int          cyc;

    always #5 CLK = ~CLK;

    system_top dut (
        .CLK(CLK), .nRST(nRST), .SW(SW), .LEDR(LEDR),
        .tbCTRL(tbCTRL), .REN(REN), .WEN(WEN), .addr(addr),
        .store(store), .load(load), .halt(halt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    localparam logic [31:0] HALT_I = {6'h3F, 26'h0};

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        tbCTRL = 1'b1; addr = a; store = d; WEN = 1'b1;
        @(posedge CLK); #1;
        WEN = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        tbCTRL = 1'b1; addr = a; REN = 1'b1;
        @(posedge CLK); #1;
        REN = 1'b0;
        d = load;
    endtask

    task automatic load_prog();
        foreach (prog[i]) host_write(32'(i * 4), prog[i]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        tbCTRL = 1'b1; nRST = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b0;
    endtask

    // Hand the RAM to the core and count edges until halt (stall edges included)
    task automatic run_prog(input int stall_at, output int cycles);
        int n;
        n = 0;
        @(negedge CLK);
        tbCTRL = 1'b0;
        while (n < 200) begin
            @(posedge CLK); n++; #1;
            if (halt) break;
            if (n == stall_at) begin
                tbCTRL = 1'b1;
                repeat (5) @(posedge CLK);
                n += 5;
                #1 tbCTRL = 1'b0;
            end
        end
        tbCTRL = 1'b1;
        cycles = n;
    endtask

    initial begin
        nRST = 1'b1; tbCTRL = 1'b1; REN = 1'b0; WEN = 1'b0;
        addr = 32'h0; store = 32'h0; SW = 18'h2A5A5;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b0;

        // reset state
        check("rst_halt", {31'h0, halt}, 32'h0);
        check("rst_load", load, 32'h0);
        check("rst_ledr", {14'h0, LEDR}, 32'h0);

        // host load / readback, simultaneous write+read, address wrap
        host_write(32'h10, 32'hDEADBEEF);
        host_read(32'h10, rd_val);
        check("host_rd", rd_val, 32'hDEADBEEF);
        check("host_halt", {31'h0, halt}, 32'h0);
        host_write(32'h14, 32'h11111111);
        @(negedge CLK);
        addr = 32'h14; store = 32'h22222222; WEN = 1'b1; REN = 1'b1;
        @(posedge CLK); #1;
        WEN = 1'b0; REN = 1'b0;
        check("wr_rd_old", load, 32'h11111111);
        host_read(32'h14, rd_val);
        check("wr_rd_new", rd_val, 32'h22222222);
        host_read(32'h10 + 32'(1024 * 4), rd_val);
        check("addr_wrap", rd_val, 32'hDEADBEEF);

        // arithmetic then store
        prog = '{enc_i(6'h09, 5'd0, 5'd1, 16'd5),
                 enc_i(6'h09, 5'd0, 5'd2, 16'hFFFD),
                 enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21),
                 enc_i(6'h2B, 5'd0, 5'd3, 16'h0100),
                 HALT_I};
        load_prog();
        run_prog(0, cyc);
        check("arith_cyc", 32'(cyc), 32'd11);
        check("arith_halt", {31'h0, halt}, 32'h1);
        host_read(32'h100, rd_val);
        check("arith_mem", rd_val, 32'h00000002);

        // reset while halted, then rerun
        do_reset();
        check("rh_halt", {31'h0, halt}, 32'h0);
        check("rh_load", load, 32'h0);
        host_write(32'h100, 32'h0);
        run_prog(0, cyc);
        check("rerun_cyc", 32'(cyc), 32'd11);
        host_read(32'h100, rd_val);
        check("rerun_mem", rd_val, 32'h00000002);

        // LUI/ORI and a taken BEQ skipping a store
        do_reset();
        host_write(32'h104, 32'hFFFFFFFF);
        prog = '{enc_i(6'h0F, 5'd0, 5'd1, 16'h1234),
                 enc_i(6'h0D, 5'd1, 5'd1, 16'h5678),
                 enc_i(6'h04, 5'd0, 5'd0, 16'd1),
                 enc_i(6'h2B, 5'd0, 5'd0, 16'h0104),
                 enc_i(6'h2B, 5'd0, 5'd1, 16'h0104),
                 HALT_I};
        load_prog();
        run_prog(0, cyc);
        check("br_cyc", 32'(cyc), 32'd11);
        host_read(32'h104, rd_val);
        check("br_mem", rd_val, 32'h12345678);

        // $0 stays zero, unknown opcode is a NOP; then same run with a 5-cycle stall
        prog = '{enc_i(6'h09, 5'd0, 5'd0, 16'd7),
                 enc_i(6'h2B, 5'd0, 5'd0, 16'h0108),
                 enc_i(6'h09, 5'd0, 5'd1, 16'd9),
                 enc_i(6'h3E, 5'd0, 5'd1, 16'h1234),
                 enc_i(6'h2B, 5'd0, 5'd1, 16'h010C),
                 HALT_I};
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            host_write(32'h108, 32'hFFFFFFFF);
            host_write(32'h10C, 32'h0);
            load_prog();
            run_prog((pass == 0) ? 0 : 4, cyc);
            check((pass == 0) ? "r0_cyc" : "stall_cyc", 32'(cyc), (pass == 0) ? 32'd14 : 32'd19);
            host_read(32'h108, rd_val);
            check((pass == 0) ? "r0_mem" : "stall_r0_mem", rd_val, 32'h0);
            host_read(32'h10C, rd_val);
            check((pass == 0) ? "nop_mem" : "stall_nop_mem", rd_val, 32'h9);
        end

        // SUBU/SLT/SLL, BNE taken, LW, J
        do_reset();
        prog = '{enc_i(6'h09, 5'd0, 5'd1, 16'hFFFD),
                 enc_i(6'h09, 5'd0, 5'd2, 16'd5),
                 enc_r(5'd2, 5'd1, 5'd3, 5'd0, 6'h23),
                 enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h2A),
                 enc_r(5'd0, 5'd2, 5'd5, 5'd4, 6'h00),
                 enc_i(6'h05, 5'd4, 5'd0, 16'd1),
                 enc_i(6'h09, 5'd0, 5'd5, 16'd0),
                 enc_i(6'h2B, 5'd0, 5'd3, 16'h0110),
                 enc_i(6'h2B, 5'd0, 5'd4, 16'h0114),
                 enc_i(6'h2B, 5'd0, 5'd5, 16'h0118),
                 enc_i(6'h23, 5'd0, 5'd6, 16'h0110),
                 {6'h02, 26'h000000D},
                 enc_i(6'h2B, 5'd0, 5'd0, 16'h0110),
                 enc_i(6'h2B, 5'd0, 5'd6, 16'h011C),
                 HALT_I};
        load_prog();
        run_prog(0, cyc);
        check("mix_cyc", 32'(cyc), 32'd32);
        host_read(32'h110, rd_val); check("subu", rd_val, 32'h8);
        host_read(32'h114, rd_val); check("slt", rd_val, 32'h1);
        host_read(32'h118, rd_val); check("sll_bne", rd_val, 32'h50);
        host_read(32'h11C, rd_val); check("lw_j", rd_val, 32'h8);

        // switch/LED window (ordinary wrapped RAM when disabled)
        do_reset();
        prog = '{enc_i(6'h23, 5'd0, 5'd1, 16'hF004),
                 enc_i(6'h2B, 5'd0, 5'd1, 16'hF000),
                 HALT_I};
        load_prog();
        run_prog(0, cyc);
        check("io_cyc", 32'(cyc), 32'd9);
        host_read(32'h0, rd_val);
`ifdef SYSTEM_MMIO_EN
        check("io_ledr", {14'h0, LEDR}, 32'h0002A5A5);
        check("io_ram0", rd_val, enc_i(6'h23, 5'd0, 5'd1, 16'hF004));
`else
        check("io_ledr", {14'h0, LEDR}, 32'h0);
        check("io_ram0", rd_val, enc_i(6'h2B, 5'd0, 5'd1, 16'hF000));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/system_top.md
# system_top

Top-level processor system (`system`, exported via `system_if`): a small multi-cycle MIPS-subset core, a unified word RAM and an optional switch/LED I/O window. It sits directly under the board wrapper or testbench. A host takes over the RAM through `system_if` (`tbCTRL`) to preload programs and read results after `halt`.

## Interface
- Parameters:
  - `RAM_WORDS`, default 1024: RAM depth in 32-bit words.
  - `PC_RESET`, default 32'h0: fetch address after reset.
- Clock and reset:
  - `CLK` in 1: system clock.
  - `nRST` in 1: reset. One clock; reset is synchronous and active-high.
- Board I/O:
  - `SW` in 18: switch inputs.
  - `LEDR` out 18: LED register.
- `syif` (`system_if`) host port:
  - `tbCTRL` in 1: host owns the RAM; the core stalls.
  - `REN` in 1: host read strobe.
  - `WEN` in 1: host write strobe.
  - `addr` in 32: host byte address.
  - `store` in 32: host write data.
  - `load` out 32: host read data.
  - `halt` out 1: sticky halted flag.

## Operation
- RAM is word addressed by byte address `addr[log2(RAM_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo the RAM size.
- RAM has one synchronous port: reads return data the following cycle.
- `tbCTRL`=1 gives the port to the host:
  - `WEN` writes `store`.
  - `REN` reads into `load`.
  - If `WEN` and `REN` are both asserted, both act, and `load` returns the old data.
- `tbCTRL`=0: `load` holds its last value, and host `WEN`/`REN` are ignored.
- Core states:
  - FETCH: issue read at PC.
  - EXEC: decode the returned word, then:
    - ALU ops: write the register file and update PC → FETCH.
    - LW/SW → MEM.
    - HALT → HALTED.
  - MEM: for SW, write → FETCH; for LW, issue read → WB.
  - WB: write rt → FETCH.
  - HALTED: absorbing state.
- Core advances only when `tbCTRL`=0. With `tbCTRL`=1 all core state freezes, and execution resumes where it stopped when `tbCTRL` returns to 0.
- Register file: 32×32; `$0` always reads as 0 and writes to it are dropped.
- Supported instructions:
  - R-type (op 0): ADDU 0x21, SUBU 0x23, AND 0x24, OR 0x25, SLT 0x2A (signed), SLL 0x00 (by shamt).
  - I-type: ADDIU 0x09 (sign-extended), ORI 0x0D (zero-extended), LUI 0x0F, LW 0x23, SW 0x2B (base + sign-extended imm).
  - Branches: BEQ 0x04, BNE 0x05; taken target = PC+4+(sext(imm)<<2).
  - Jump: J 0x02; target {PC+4[31:28], imm26, 2'b00}.
  - HALT: op 0x3F.
- No branch delay slot. Arithmetic is modulo 2^32 with no overflow traps.
- Unknown opcodes or functs execute as NOP: PC+4, no register or memory effect.
- Memory-access alignment: `addr[1:0]` is ignored.
- `halt` goes to 1 when HALT executes and stays 1 until reset.

## Timing
- Reset (`nRST`=1 at a CLK edge) sets: PC=`PC_RESET`, state FETCH, registers 0, `halt`=0, `load`=0, `LEDR`=0. RAM contents are preserved.
- Reset has priority over everything, including mid-instruction and in HALTED.
- Cycles per instruction: 2 for ALU, branch, J and HALT; 3 for SW; 4 for LW.
- `halt` rises at the edge that ends the HALT instruction's EXEC cycle.
- Host read latency: `load` is valid one cycle after the `REN` edge.
- Host write: the RAM holds the new value from the next cycle.

## Configuration
- `SYSTEM_MMIO_EN` defined:
  - SW to byte address 0x0000F000 latches `LEDR` ← data[17:0]; RAM is not written.
  - LW from 0x0000F004 returns {14'b0, `SW`}, sampled in the MEM cycle.
  - The host port always reaches RAM only.
- Undefined: `LEDR` is constant 0, and those addresses are ordinary (wrapped) RAM.

## Test plan
- Host load and readback: reset, then with `tbCTRL`=1 write 0xDEADBEEF to addr 0x10, REN addr 0x10 → `load`=0xDEADBEEF the next cycle; `halt`=0.
- Arithmetic then store:
  - Program: ADDIU $1,$0,5; ADDIU $2,$0,-3; ADDU $3,$1,$2; SW $3,0x100($0); HALT.
  - Run with `tbCTRL`=0 → `halt`=1 after 11 cycles; word 0x100 reads 0x00000002.
- Branch/LUI:
  - Program: LUI $1,0x1234; ORI $1,$1,0x5678; BEQ $0,$0,+1; skipped SW of $0 to 0x104; SW $1,0x104; HALT.
  - Result → 0x104=0x12345678.
- Stall: assert `tbCTRL` for 5 cycles mid-program → final memory identical and cycle count +5; `$0` write via ADDIU $0,$0,7 then SW $0 → 0.
- Reset in HALTED: pulse `nRST` → `halt`=0, program reruns from `PC_RESET`.
- With `SYSTEM_MMIO_EN`: `SW`=0x2A5A5 (18-bit); LW $1,0xF004($0); SW $1,0xF000($0); HALT → `LEDR`=0x2A5A5. Without the macro → `LEDR`=0.
